run_ctrl: RTL and testbench
===========================

# run_ctrl

Run controller that sits directly upstream of the X9 core top level. It accepts a start request from the host or testbench and holds the core in reset for a fixed window. It then pulses the core's `req`, watches the core's `done`, and measures the run length in cycles. It ends the run on a qualified `done`, a watchdog timeout or a host abort, and reports a status and cycle count through a one-cycle acknowledge.

## Interface
Parameters:
- `CW`, 16, width of the cycle counter, `timeout_lim` and `result_cycles`
- `RST_CYC`, 4, number of cycles `core_reset` is held in the RESET state (≥1)
- `DONE_HOLD`, 2, number of consecutive cycles `core_done` must be high to qualify (≥1)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `host_start`  in  1  start request; sampled only in IDLE
- `host_abort`  in  1  abort request; honoured in RESET, REQ, RUN
- `timeout_lim`  in  CW  watchdog limit in RUN cycles; 0 disables the watchdog; sampled every cycle
- `host_busy`  out  1  high from RESET entry through the REPORT cycle
- `host_ack`  out  1  one-cycle pulse in REPORT
- `result_status`  out  2  00 ok, 01 timeout, 10 aborted, 11 never driven
- `result_cycles`  out  CW  RUN-cycle count latched at run end
- `core_reset`  out  1  active-high reset to core top level
- `core_req`  out  1  to core `req`
- `core_done`  in  1  from core `done`

## Operation
- States: IDLE, RESET, REQ, RUN, REPORT.
- IDLE: `core_reset`=1. `host_start`=1 moves to RESET.
- RESET: `core_reset`=1 for exactly RST_CYC cycles, then moves to REQ. Abort moves to REPORT with status 10 and cycles 0.
- REQ: one cycle. `core_reset`=0 and `core_req`=1. The counter clears to 0. Abort moves to REPORT with status 10 and cycles 0; otherwise the FSM moves to RUN.
- RUN: `core_reset`=0 and `core_req`=0. The counter increments each cycle and saturates at all-ones.
- Done qualification counts consecutive high samples of `core_done` in RUN only. It clears on any low sample.
- Run end is evaluated on the post-increment count, with this priority:
  1. Qualified done → status 00.
  2. `host_abort` → status 10.
  3. `timeout_lim`≠0 and count==`timeout_lim` → status 01.
- At run end the FSM moves to REPORT, and `result_cycles` latches the post-increment count.
- REPORT: one cycle. `host_ack`=1 and `core_reset`=1. The FSM then returns to IDLE.
- `result_status` and `result_cycles` change only on REPORT entry. They hold until the next REPORT.
- `host_start` outside IDLE is ignored and is not queued. `host_abort` in IDLE or REPORT is ignored.
- A count that saturates below a nonzero `timeout_lim` never times out. The run waits for done or abort.

## Timing
- Reset values: `core_reset`=1, `core_req`=0, `host_busy`=0, `host_ack`=0, `result_status`=00, `result_cycles`=0, state IDLE.
- Reset asserted mid-run returns to IDLE asynchronously with the values above. No `host_ack` is produced.
- With `host_start` sampled at edge 0:
  - RESET occupies cycles 1..RST_CYC.
  - REQ is cycle RST_CYC+1.
  - The first RUN cycle is RST_CYC+2.
- `core_done` high from RUN cycle k, held: done qualifies in RUN cycle k+DONE_HOLD−1. That value is reported as `result_cycles`. REPORT follows the next cycle.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Configuration
- Macro `RUN_CTRL_PERF_EN`.
- Defined:
  - Adds output `run_count`, 8 bits, reset 0.
  - `run_count` increments by 1 on each REPORT entry with status 00 and wraps 255→0.
  - Aborted and timed-out runs do not increment it.
- Undefined: the `run_count` port and its logic are absent. All other behaviour is identical.

## Test plan
- Normal run:
  - Stimulus: RST_CYC=4, DONE_HOLD=2, `timeout_lim`=0, start at edge 0; `core_done` high from RUN cycle 10 onward.
  - Response: `core_reset` high for cycles 1–4, `core_req` high only on cycle 5, a single `host_ack`, status 00, `result_cycles`=11.
- Glitch rejection:
  - Stimulus: `core_done` pulses for one cycle at RUN cycle 5, then is high from RUN cycle 20.
  - Response: status 00, `result_cycles`=21.
- Watchdog:
  - Stimulus: `timeout_lim`=50, `core_done` held low.
  - Response: `host_ack` after RUN cycle 50, status 01, `result_cycles`=50, `core_reset` back to 1.
- Abort and priority:
  - Stimulus A: `host_abort` at RUN cycle 7 with done low. Response: status 10, `result_cycles`=7.
  - Stimulus B: abort in RESET. Response: status 10, `result_cycles`=0.
  - Stimulus C: abort in the same cycle done qualifies. Response: status 00.
- Ignore and reset:
  - Stimulus A: `host_start` pulsed during RUN. Response: no effect on the run.
  - Stimulus B: `reset` driven low at RUN cycle 3. Response: immediately `core_reset`=1, `host_busy`=0, outputs at reset values, no `host_ack`.
- `RUN_CTRL_PERF_EN`:
  - Stimulus: two ok runs, one timeout, one abort.
  - Response: `run_count`=2.

Source files
------------

// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : run_ctrl
// Brief    : Run controller for the X9 core: reset window, req pulse, done
//            qualification, watchdog/abort and cycle-count reporting.
//            Optional feature macro: RUN_CTRL_PERF_EN (adds run_count output).
// Revision : 1.0 - initial release
// ============================================================================
module run_ctrl #(
    parameter int CW        = 16,
    parameter int RST_CYC   = 4,
    parameter int DONE_HOLD = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_start,
    input  logic          host_abort,
    input  logic [CW-1:0] timeout_lim,
    output logic          host_busy,
    output logic          host_ack,
    output logic [1:0]    result_status,
    output logic [CW-1:0] result_cycles,
    output logic          core_reset,
    output logic          core_req,
    input  logic          core_done
`ifdef RUN_CTRL_PERF_EN
    ,
    output logic [7:0]    run_count
`endif
);

    localparam int          c_RW       = $clog2(RST_CYC + 1);
    localparam int          c_HW       = $clog2(DONE_HOLD + 1);
    localparam logic [c_RW-1:0] c_RST_LAST = c_RW'(RST_CYC - 1);
    localparam logic [c_HW-1:0] c_HOLD_MAX = c_HW'(DONE_HOLD);

    localparam logic [1:0] c_ST_OK      = 2'b00;
    localparam logic [1:0] c_ST_TIMEOUT = 2'b01;
    localparam logic [1:0] c_ST_ABORT   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_REQ    = 3'd2,
        S_RUN    = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [c_RW-1:0] r_rst_cnt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_inc;
    logic [c_HW-1:0] r_hold;
    logic [c_HW-1:0] w_hold_inc;
    logic            w_done_q;
    logic [1:0]      w_status;
    logic [CW-1:0]   w_cycles;

    logic            r_host_busy;
    logic            r_host_ack;
    logic [1:0]      r_result_status;
    logic [CW-1:0]   r_result_cycles;
    logic            r_core_reset;
    logic            r_core_req;

    always_comb begin
        w_state_next = r_state;
        w_status     = c_ST_OK;
        w_cycles     = '0;
        w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
        // Streak of consecutive high done samples, saturating at the qualify threshold
        if (core_done) begin
            w_hold_inc = (r_hold == c_HOLD_MAX) ? c_HOLD_MAX : r_hold + 1'b1;
        end else begin
            w_hold_inc = '0;
        end
        w_done_q = (w_hold_inc == c_HOLD_MAX);

        case (r_state)
            S_IDLE: begin
                if (host_start) w_state_next = S_RESET;
            end
            S_RESET: begin
                if (host_abort) begin
                    w_state_next = S_REPORT;
                    w_status     = c_ST_ABORT;
                end else if (r_rst_cnt == c_RST_LAST) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (host_abort) begin
                    w_state_next = S_REPORT;
                    w_status     = c_ST_ABORT;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_cycles = w_cnt_inc;
                if (w_done_q) begin
                    w_state_next = S_REPORT;
                    w_status     = c_ST_OK;
                end else if (host_abort) begin
                    w_state_next = S_REPORT;
                    w_status     = c_ST_ABORT;
                end else if (timeout_lim != '0 && w_cnt_inc == timeout_lim) begin
                    w_state_next = S_REPORT;
                    w_status     = c_ST_TIMEOUT;
                end
            end
            S_REPORT: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_rst_cnt       <= '0;
            r_cnt           <= '0;
            r_hold          <= '0;
            r_host_busy     <= 1'b0;
            r_host_ack      <= 1'b0;
            r_result_status <= 2'b00;
            r_result_cycles <= '0;
            r_core_reset    <= 1'b1;
            r_core_req      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rst_cnt <= (r_state == S_RESET) ? r_rst_cnt + 1'b1 : '0;
            r_hold    <= (r_state == S_RUN) ? w_hold_inc : '0;
            if (r_state == S_REQ) begin
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_cnt <= w_cnt_inc;
            end
            // Outputs are decoded from the next state so they leave as flops
            r_host_busy  <= (w_state_next != S_IDLE);
            r_host_ack   <= (w_state_next == S_REPORT);
            r_core_req   <= (w_state_next == S_REQ);
            r_core_reset <= (w_state_next == S_IDLE) || (w_state_next == S_RESET) ||
                            (w_state_next == S_REPORT);
            if (w_state_next == S_REPORT) begin
                r_result_status <= w_status;
                r_result_cycles <= w_cycles;
            end
        end
    end

`ifdef RUN_CTRL_PERF_EN
    logic [7:0] r_run_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run_count <= 8'd0;
        end else if (w_state_next == S_REPORT && w_status == c_ST_OK) begin
            r_run_count <= r_run_count + 8'd1;
        end
    end

    assign run_count = r_run_count;
`endif

    assign host_busy     = r_host_busy;
    assign host_ack      = r_host_ack;
    assign result_status = r_result_status;
    assign result_cycles = r_result_cycles;
    assign core_reset    = r_core_reset;
    assign core_req      = r_core_req;

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_ctrl
// Brief    : Randomized self-checking bench for run_ctrl with a per-run
//            behavioural model of the expected outcome.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_ctrl;

    localparam int CW        = 16;
    localparam int RST_CYC   = 4;
    localparam int DONE_HOLD = 2;
    localparam int MAXC      = 200;
    localparam int PW        = CW + 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          host_start = 1'b0;
    logic          host_abort = 1'b0;
    logic          core_done = 1'b0;
    logic [CW-1:0] timeout_lim = '0;
    logic          host_busy;
    logic          host_ack;
    logic [1:0]    result_status;
    logic [CW-1:0] result_cycles;
    logic          core_reset;
    logic          core_req;
`ifdef RUN_CTRL_PERF_EN
    logic [7:0]    run_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Scenario description and model state
    logic          done_pat [0:MAXC];
    int            abort_c;
    logic [CW-1:0] lim;
    logic [1:0]    exp_status;
    int            exp_cycles;
    int            ok_runs;

    always #5 clk = ~clk;

    run_ctrl #(.CW(CW), .RST_CYC(RST_CYC), .DONE_HOLD(DONE_HOLD)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .host_start    (host_start),
        .host_abort    (host_abort),
        .timeout_lim   (timeout_lim),
        .host_busy     (host_busy),
        .host_ack      (host_ack),
        .result_status (result_status),
        .result_cycles (result_cycles),
        .core_reset    (core_reset),
        .core_req      (core_req),
        .core_done     (core_done)
`ifdef RUN_CTRL_PERF_EN
        ,
        .run_count     (run_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] pack(input logic rst, input logic req, input logic busy,
                                           input logic ack, input logic [1:0] st, input int cyc);
        return {rst, req, busy, ack, st, CW'(cyc)};
    endfunction

    function automatic logic [PW-1:0] observed();
        return {core_reset, core_req, host_busy, host_ack, result_status, result_cycles};
    endfunction

    task automatic clear_pat();
        for (int c = 0; c <= MAXC; c++) done_pat[c] = 1'b0;
        abort_c = 0;
        lim     = '0;
    endtask

    task automatic set_done_from(input int c0);
        for (int c = c0; c <= MAXC; c++) done_pat[c] = 1'b1;
    endtask

    // Walk RUN cycles k = 1, 2, ... applying the run-end rules in priority order.
    task automatic predict(output int rep_c, output logic [1:0] st, output int cyc);
        int streak;
        int c;
        streak = 0;
        rep_c  = -1;
        st     = 2'b00;
        cyc    = 0;
        if (abort_c >= 1 && abort_c <= RST_CYC + 1) begin
            rep_c = abort_c + 1;
            st    = 2'b10;
            return;
        end
        for (int k = 1; RST_CYC + 1 + k < MAXC - 3; k++) begin
            c      = RST_CYC + 1 + k;
            streak = done_pat[c] ? streak + 1 : 0;
            if (streak >= DONE_HOLD) begin
                st = 2'b00;
            end else if (c == abort_c) begin
                st = 2'b10;
            end else if (lim != 0 && k == int'(lim)) begin
                st = 2'b01;
            end else begin
                continue;
            end
            rep_c = c + 1;
            cyc   = k;
            return;
        end
    endtask

    // Start at edge 0; cycle c is the interval following edge c.
    task automatic do_run(input string name);
        int         rep_c;
        logic [1:0] st;
        int         cyc;
        logic [PW-1:0] exp;
        predict(rep_c, st, cyc);
        timeout_lim = lim;
        @(posedge clk); #1 host_start = 1'b1;
        @(posedge clk); #1 host_start = 1'b0;
        for (int c = 1; c <= rep_c + 2; c++) begin
            core_done  = done_pat[c];
            host_abort = (c == abort_c) || (c == rep_c && $urandom_range(0, 1) == 1);
            host_start = (c <= rep_c) && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (c < rep_c)
                exp = pack(c <= RST_CYC, c == RST_CYC + 1, 1'b1, 1'b0, exp_status, exp_cycles);
            else if (c == rep_c)
                exp = pack(1'b1, 1'b0, 1'b1, 1'b1, st, cyc);
            else
                exp = pack(1'b1, 1'b0, 1'b0, 1'b0, st, cyc);
            check($sformatf("%s_c%0d", name, c), 64'(observed()), 64'(exp));
            @(posedge clk); #1;
        end
        core_done  = 1'b0;
        host_abort = 1'b0;
        host_start = 1'b0;
        exp_status = st;
        exp_cycles = cyc;
        if (st == 2'b00) ok_runs++;
    endtask

    task automatic reset_mid_run();
        clear_pat();
        set_done_from(RST_CYC + 1 + 30);
        timeout_lim = '0;
        @(posedge clk); #1 host_start = 1'b1;
        @(posedge clk); #1 host_start = 1'b0;
        repeat (RST_CYC + 3) @(posedge clk);
        #1;
        check("rst_pre_run", 64'({core_reset, core_req, host_busy}), 64'(3'b001));
        #2 reset = 1'b0;
        #1;
        check("rst_async", 64'(observed()), 64'(pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 0)));
        @(posedge clk); #1 reset = 1'b1;
        exp_status = 2'b00;
        exp_cycles = 0;
        ok_runs    = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_idle%0d", i), 64'(observed()),
                  64'(pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 0)));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int dens;
        exp_status = 2'b00;
        exp_cycles = 0;
        ok_runs    = 0;
        clear_pat();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'(observed()), 64'(pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 0)));
        @(posedge clk); #1 reset = 1'b1;

        reset_mid_run();

        // Normal: done from RUN cycle 10
        clear_pat(); set_done_from(RST_CYC + 1 + 10);
        do_run("normal");
        check("normal_cycles", 64'(result_cycles), 64'd11);

        // Glitch at RUN 5, then done from RUN 20
        clear_pat(); done_pat[RST_CYC + 1 + 5] = 1'b1; set_done_from(RST_CYC + 1 + 20);
        do_run("glitch");
        check("glitch_cycles", 64'(result_cycles), 64'd21);

        // Watchdog
        clear_pat(); lim = CW'(50);
        do_run("wdog");
        check("wdog_result", 64'({result_status, result_cycles}), 64'({2'b01, 16'd50}));

        // Abort in RUN 7
        clear_pat(); abort_c = RST_CYC + 1 + 7;
        do_run("abortA");
        check("abortA_result", 64'({result_status, result_cycles}), 64'({2'b10, 16'd7}));

        // Abort in RESET
        clear_pat(); abort_c = 2;
        do_run("abortB");
        check("abortB_result", 64'({result_status, result_cycles}), 64'({2'b10, 16'd0}));

        // Abort in the qualifying cycle: done wins
        clear_pat(); set_done_from(RST_CYC + 1 + 10); abort_c = RST_CYC + 1 + 11;
        do_run("abortC");
        check("abortC_result", 64'({result_status, result_cycles}), 64'({2'b00, 16'd11}));

        // Abort in REQ
        clear_pat(); abort_c = RST_CYC + 1;
        do_run("abortREQ");

        // Timeout at the very first RUN cycle
        clear_pat(); lim = CW'(1);
        do_run("lim1");

        for (int r = 0; r < 24; r++) begin
            clear_pat();
            dens = $urandom_range(2, 12);
            for (int c = 0; c <= MAXC; c++) done_pat[c] = ($urandom_range(0, dens - 1) == 0);
            lim = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 100));
            if ($urandom_range(0, 2) == 0) abort_c = $urandom_range(1, RST_CYC + 40);
            if (lim == '0) set_done_from(110);
            do_run($sformatf("rnd%0d", r));
        end

`ifdef RUN_CTRL_PERF_EN
        check("run_count", 64'(run_count), 64'(ok_runs % 256));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
